// File: rtl/mips_hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states and
// the iteration-counter width helper.
package mips_hilo_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_RSV6  = 3'd6,
      OP_RSV7  = 3'd7
   } hilo_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } hilo_state_t;

   localparam int HILO_WIDTH_DEFAULT = 32;
   localparam int HILO_CNT_W_DEFAULT = $clog2(HILO_WIDTH_DEFAULT);

   function automatic int hilo_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mips_hilo_iter_core.sv
// Shared iterative datapath: one 2W-bit shift register and one adder that do
// either a shift-add multiply step or a restoring-divide step per cycle.
module mips_hilo_iter_core
   import mips_hilo_pkg::*;
#(
   parameter int WIDTH = HILO_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               load,
   input  logic               step,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   load_lo,
   input  logic [WIDTH-1:0]   load_opnd,
   output logic [2*WIDTH-1:0] acc
);

   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH:0]     base;
   logic [WIDTH:0]     addend;
   logic               cin;
   logic [WIDTH+1:0]   sum;
   logic               ge;
   logic [2*WIDTH-1:0] acc_next;

   assign acc_hi = acc[2*WIDTH-1:WIDTH];

   // Divide subtracts via inverted addend plus carry-in; the carry out of the
   // extra top bit is the "partial remainder >= divisor" decision.
   always_comb begin
      base   = {1'b0, acc_hi};
      addend = {1'b0, opnd};
      cin    = 1'b0;
      if (div_mode) begin
         base   = {acc_hi, acc[WIDTH-1]};
         addend = ~{1'b0, opnd};
         cin    = 1'b1;
      end
      sum = {1'b0, base} + {1'b0, addend} + {{(WIDTH+1){1'b0}}, cin};
      ge  = sum[WIDTH+1];
      if (div_mode) begin
         if (ge)
            acc_next = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {base[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         if (acc[0])
            acc_next = {sum[WIDTH:0], acc[WIDTH-1:1]};
         else
            acc_next = {1'b0, acc_hi, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         opnd <= '0;
      end else if (en) begin
         if (load) begin
            acc  <= {{WIDTH{1'b0}}, load_lo};
            opnd <= load_opnd;
         end else if (step) begin
            acc  <= acc_next;
         end
      end
   end

endmodule

// File: rtl/mips_hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: FSM, sign handling, single-cycle op stage,
// HI/LO registers and the valid/ready/busy/done handshake.
//
// state | meaning
// IDLE  | op_ready high; accepts ops, single-cycle ops retire from here
// MUL   | one shift-add multiply step per enabled cycle, WIDTH steps
// DIV   | one restoring-divide step per enabled cycle, WIDTH steps
// FIX   | apply result signs, write HI/LO, return to IDLE
module mips_hilo_muldiv_unit
   import mips_hilo_pkg::*;
#(
   parameter int WIDTH     = HILO_WIDTH_DEFAULT,
   parameter bit FAST_MULT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             op_ready,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               CNT_W    = hilo_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   hilo_state_t        state, state_nx;
   hilo_op_t           op;
   logic [CNT_W-1:0]   cnt;
   logic               accept;
   logic               is_signed;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               iterating;

   logic               core_load, core_div;
   logic [WIDTH-1:0]   core_lo, core_opnd;
   logic [2*WIDTH-1:0] acc;
   logic               fix_div, neg_lo, neg_hi;
   logic [2*WIDTH-1:0] fix_prod;
   logic [2*WIDTH-1:0] fast_prod;

   logic               pn_valid, pn_whi, pn_wlo, pn_dbz;
   logic [WIDTH-1:0]   pn_hi, pn_lo;
   logic               p_valid, p_whi, p_wlo, p_dbz;
   logic [WIDTH-1:0]   p_hi, p_lo;

   logic               wr_done, wr_dbz, wr_hi, wr_lo;
   logic [WIDTH-1:0]   new_hi, new_lo;

   assign op        = hilo_op_t'(op_code);
   assign op_ready  = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign accept    = op_valid & op_ready & clk_enable;
   assign iterating = (state == ST_MUL) || (state == ST_DIV);

   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg     = is_signed & op_a[WIDTH-1];
   assign b_neg     = is_signed & op_b[WIDTH-1];
   assign a_mag     = a_neg ? -op_a : op_a;
   assign b_mag     = b_neg ? -op_b : op_b;

   // Sign-extended operands give the correct 2W-bit product modulo 2^2W for
   // both signed and unsigned multiplies.
   if (FAST_MULT) begin : g_fast
      logic [2*WIDTH-1:0] fa, fb;
      assign fa        = {{WIDTH{a_neg}}, op_a};
      assign fb        = {{WIDTH{b_neg}}, op_b};
      assign fast_prod = fa * fb;
   end else begin : g_iter_only
      assign fast_prod = '0;
   end

   mips_hilo_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .reset     (reset),
      .en        (clk_enable),
      .load      (core_load),
      .step      (iterating),
      .div_mode  (core_div),
      .load_lo   (core_lo),
      .load_opnd (core_opnd),
      .acc       (acc)
   );

   always_comb begin
      state_nx  = state;
      core_load = 1'b0;
      core_div  = (state == ST_DIV);
      core_lo   = b_mag;
      core_opnd = a_mag;
      pn_valid  = 1'b0;
      pn_whi    = 1'b0;
      pn_wlo    = 1'b0;
      pn_dbz    = 1'b0;
      pn_hi     = op_a;
      pn_lo     = op_a;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     if (FAST_MULT) begin
                        pn_valid       = 1'b1;
                        pn_whi         = 1'b1;
                        pn_wlo         = 1'b1;
                        {pn_hi, pn_lo} = fast_prod;
                     end else begin
                        state_nx  = ST_MUL;
                        core_load = 1'b1;
                        core_div  = 1'b0;
                     end
                  end
                  OP_DIV, OP_DIVU: begin
                     if (op_b == '0) begin
                        pn_valid = 1'b1;
                        pn_dbz   = 1'b1;
                     end else begin
                        state_nx  = ST_DIV;
                        core_load = 1'b1;
                        core_div  = 1'b1;
                        core_lo   = a_mag;
                        core_opnd = b_mag;
                     end
                  end
                  OP_MTHI: begin
                     pn_valid = 1'b1;
                     pn_whi   = 1'b1;
                  end
                  OP_MTLO: begin
                     pn_valid = 1'b1;
                     pn_wlo   = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            if (cnt == CNT_LAST)
               state_nx = ST_FIX;
         end
         ST_FIX:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign fix_prod = neg_lo ? -acc : acc;

   always_comb begin
      wr_done = 1'b0;
      wr_dbz  = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      new_hi  = p_hi;
      new_lo  = p_lo;
      if (state == ST_FIX) begin
         wr_done = 1'b1;
         wr_hi   = 1'b1;
         wr_lo   = 1'b1;
         if (fix_div) begin
            new_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            new_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
         end else begin
            new_lo = fix_prod[WIDTH-1:0];
            new_hi = fix_prod[2*WIDTH-1:WIDTH];
         end
      end else if (p_valid) begin
         wr_done = 1'b1;
         wr_dbz  = p_dbz;
         wr_hi   = p_whi;
         wr_lo   = p_wlo;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         fix_div <= 1'b0;
         neg_lo  <= 1'b0;
         neg_hi  <= 1'b0;
      end else if (clk_enable) begin
         state <= state_nx;
         cnt   <= (iterating && cnt != CNT_LAST) ? cnt + CNT_W'(1) : '0;
         if (core_load) begin
            fix_div <= core_div;
            neg_lo  <= a_neg ^ b_neg;
            neg_hi  <= a_neg;
         end
      end
   end

   // Single-cycle ops are staged for one edge so they retire at accept+1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_valid <= 1'b0;
         p_whi   <= 1'b0;
         p_wlo   <= 1'b0;
         p_dbz   <= 1'b0;
         p_hi    <= '0;
         p_lo    <= '0;
      end else if (clk_enable) begin
         p_valid <= pn_valid;
         p_whi   <= pn_whi;
         p_wlo   <= pn_wlo;
         p_dbz   <= pn_dbz;
         p_hi    <= pn_hi;
         p_lo    <= pn_lo;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else if (clk_enable) begin
         if (wr_hi) hi <= new_hi;
         if (wr_lo) lo <= new_lo;
         done        <= wr_done;
         div_by_zero <= wr_dbz;
      end
   end

endmodule

// File: tb/tb_mips_hilo_muldiv_unit.sv
// Directed bench for the HI/LO unit: a 32-bit iterative instance, a 32-bit
// FAST_MULT instance and a 16-bit instance share one stimulus bus.
module tb_mips_hilo_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_enable = 1'b1;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = 3'd0;
   logic [31:0] op_a = 32'h0;
   logic [31:0] op_b = 32'h0;

   logic        r0_ready, r0_busy, r0_done, r0_dbz;
   logic [31:0] r0_hi, r0_lo;
   logic        r1_ready, r1_busy, r1_done, r1_dbz;
   logic [31:0] r1_hi, r1_lo;
   logic        r2_ready, r2_busy, r2_done, r2_dbz;
   logic [15:0] r2_hi, r2_lo;

   int total = 0;
   int bad   = 0;

   logic [2:0]  dv_code [4] = '{3'd2, 3'd3, 3'd2, 3'd2};
   logic [31:0] dv_a    [4] = '{32'hFFFF_FFF9, 32'h7, 32'h8000_0000, 32'h7};
   logic [31:0] dv_b    [4] = '{32'h2, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
   logic [31:0] dv_lo   [4] = '{32'hFFFF_FFFD, 32'h3, 32'h8000_0000, 32'hFFFF_FFFD};
   logic [31:0] dv_hi   [4] = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1};

   always #5 clk = ~clk;

   mips_hilo_muldiv_unit #(.WIDTH(32), .FAST_MULT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .op_valid(op_valid),
      .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_ready(r0_ready),
      .busy(r0_busy), .done(r0_done), .div_by_zero(r0_dbz), .hi(r0_hi), .lo(r0_lo));

   mips_hilo_muldiv_unit #(.WIDTH(32), .FAST_MULT(1'b1)) dut1 (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .op_valid(op_valid),
      .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_ready(r1_ready),
      .busy(r1_busy), .done(r1_done), .div_by_zero(r1_dbz), .hi(r1_hi), .lo(r1_lo));

   mips_hilo_muldiv_unit #(.WIDTH(16), .FAST_MULT(1'b0)) dut2 (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .op_valid(op_valid),
      .op_code(op_code), .op_a(op_a[15:0]), .op_b(op_b[15:0]), .op_ready(r2_ready),
      .busy(r2_busy), .done(r2_done), .div_by_zero(r2_dbz), .hi(r2_hi), .lo(r2_lo));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sel_done(input int sel);
      case (sel)
         0:       return r0_done;
         1:       return r1_done;
         default: return r2_done;
      endcase
   endfunction

   function automatic logic sel_busy(input int sel);
      case (sel)
         0:       return r0_busy;
         1:       return r1_busy;
         default: return r2_busy;
      endcase
   endfunction

   // n = number of edges after the accept edge until done is seen (limit if never).
   task automatic run_op(input int sel, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, input int limit, output int n,
                         output logic busy_seen);
      op_valid = 1'b1;
      op_code  = code;
      op_a     = a;
      op_b     = b;
      tick();
      op_valid  = 1'b0;
      op_a      = 32'hA5A5_5A5A;
      op_b      = 32'h0;
      n         = 0;
      busy_seen = sel_busy(sel);
      while (!sel_done(sel) && n < limit) begin
         tick();
         n++;
         busy_seen = busy_seen | sel_busy(sel);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clk_enable = 1'b1;
      op_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      total++; if (r0_hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", r0_hi); end
      total++; if (r0_lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", r0_lo); end
      total++; if ({r0_busy, r0_done, r0_dbz} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {r0_busy, r0_done, r0_dbz}); end
      total++; if (r0_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", r0_ready); end
   endtask

   task automatic test_mthi_mtlo();
      op_valid = 1'b1;
      op_code  = 3'd4;
      op_a     = 32'h4000_0000;
      tick();
      total++; if ({r0_ready, r0_busy, r0_hi} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL mthi_pending got=%b%b/%h exp=10/00000000", r0_ready, r0_busy, r0_hi); end
      op_code = 3'd5;
      op_a    = 32'h0002_0001;
      tick();
      op_valid = 1'b0;
      total++; if ({r0_hi, r0_lo} !== {32'h4000_0000, 32'h0}) begin bad++; $display("FAIL mthi_write got=%h/%h exp=40000000/00000000", r0_hi, r0_lo); end
      total++; if ({r0_done, r0_busy} !== 2'b10) begin bad++; $display("FAIL mthi_done got=%b exp=10", {r0_done, r0_busy}); end
      tick();
      total++; if ({r0_hi, r0_lo} !== {32'h4000_0000, 32'h0002_0001}) begin bad++; $display("FAIL mtlo_write got=%h/%h exp=40000000/00020001", r0_hi, r0_lo); end
      total++; if ({r0_done, r0_busy} !== 2'b10) begin bad++; $display("FAIL mtlo_done got=%b exp=10", {r0_done, r0_busy}); end
      tick();
      total++; if (r0_done !== 1'b0) begin bad++; $display("FAIL mtlo_done_end got=%b exp=0", r0_done); end
   endtask

   task automatic test_multu();
      int n, nb, nd;
      op_valid = 1'b1;
      op_code  = 3'd1;
      op_a     = 32'h4000_0000;
      op_b     = 32'h0002_0001;
      tick();
      op_valid = 1'b0;
      op_a = 32'h0;
      op_b = 32'h0;
      n = 0; nb = 0;
      while (!r0_done && n < 100) begin
         if (r0_busy) nb++;
         tick();
         n++;
      end
      total++; if (nb !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=33", nb); end
      total++; if (n !== 33) begin bad++; $display("FAIL multu_latency got=%0d exp=33", n); end
      total++; if ({r0_hi, r0_lo} !== {32'h0000_8000, 32'h4000_0000}) begin bad++; $display("FAIL multu_result got=%h/%h exp=00008000/40000000", r0_hi, r0_lo); end
      nd = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (r0_done) nd++;
      end
      total++; if (nd !== 0) begin bad++; $display("FAIL multu_done_once extra=%0d exp=0", nd); end
   endtask

   task automatic test_mult();
      int n; logic bs;
      run_op(0, 3'd0, 32'hFFFF_FFFE, 32'h3, 100, n, bs);
      total++; if (n !== 33) begin bad++; $display("FAIL mult_latency got=%0d exp=33", n); end
      total++; if ({r0_hi, r0_lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin bad++; $display("FAIL mult_result got=%h/%h exp=ffffffff/fffffffa", r0_hi, r0_lo); end
      tick();
   endtask

   task automatic test_div();
      int n; logic bs;
      for (int i = 0; i < 4; i++) begin
         run_op(0, dv_code[i], dv_a[i], dv_b[i], 100, n, bs);
         total++; if (n !== 33) begin bad++; $display("FAIL div%0d_latency got=%0d exp=33", i, n); end
         total++; if ({r0_hi, r0_lo} !== {dv_hi[i], dv_lo[i]}) begin bad++; $display("FAIL div%0d_result got=%h/%h exp=%h/%h", i, r0_hi, r0_lo, dv_hi[i], dv_lo[i]); end
         total++; if (r0_dbz !== 1'b0) begin bad++; $display("FAIL div%0d_dbz got=%b exp=0", i, r0_dbz); end
         tick();
      end
   endtask

   task automatic test_div_by_zero();
      int n; logic bs;
      run_op(0, 3'd4, 32'h1234, 32'h0, 100, n, bs);
      run_op(0, 3'd5, 32'h5678, 32'h0, 100, n, bs);
      run_op(0, 3'd3, 32'h7, 32'h0, 100, n, bs);
      total++; if (n !== 1) begin bad++; $display("FAIL dbz_latency got=%0d exp=1", n); end
      total++; if ({r0_dbz, bs} !== 2'b10) begin bad++; $display("FAIL dbz_flag got=%b exp=10", {r0_dbz, bs}); end
      total++; if ({r0_hi, r0_lo} !== {32'h1234, 32'h5678}) begin bad++; $display("FAIL dbz_hilo got=%h/%h exp=00001234/00005678", r0_hi, r0_lo); end
      tick();
      total++; if ({r0_done, r0_dbz} !== 2'b00) begin bad++; $display("FAIL dbz_pulse_end got=%b exp=00", {r0_done, r0_dbz}); end
   endtask

   task automatic test_reserved();
      int n; logic bs;
      run_op(0, 3'd6, 32'hFFFF, 32'hFFFF, 40, n, bs);
      total++; if (n !== 40) begin bad++; $display("FAIL rsv_no_done got=%0d exp=40", n); end
      total++; if ({r0_hi, r0_lo, r0_ready} !== {32'h1234, 32'h5678, 1'b1}) begin bad++; $display("FAIL rsv_state got=%h/%h/%b exp=00001234/00005678/1", r0_hi, r0_lo, r0_ready); end
   endtask

   task automatic test_busy_ignore();
      int n, nr;
      op_valid = 1'b1;
      op_code  = 3'd1;
      op_a     = 32'h3;
      op_b     = 32'h5;
      tick();
      op_code = 3'd5;
      op_a    = 32'hDEAD;
      n = 0; nr = 0;
      while (!r0_done && n < 100) begin
         if (r0_ready) nr++;
         tick();
         n++;
      end
      op_valid = 1'b0;
      total++; if (nr !== 0) begin bad++; $display("FAIL busy_ready_low got=%0d exp=0", nr); end
      total++; if (n !== 33) begin bad++; $display("FAIL busy_latency got=%0d exp=33", n); end
      total++; if ({r0_hi, r0_lo} !== {32'h0, 32'hF}) begin bad++; $display("FAIL busy_mtlo_ignored got=%h/%h exp=00000000/0000000f", r0_hi, r0_lo); end
      tick();
      tick();
      total++; if ({r0_lo, r0_done} !== {32'hF, 1'b0}) begin bad++; $display("FAIL busy_after got=%h/%b exp=0000000f/0", r0_lo, r0_done); end
   endtask

   task automatic test_enable_freeze();
      int n;
      op_valid = 1'b1;
      op_code  = 3'd0;
      op_a     = 32'hFFFF_FFFE;
      op_b     = 32'h3;
      tick();
      op_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 3; i++) begin tick(); n++; end
      clk_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin tick(); n++; end
      total++; if ({r0_busy, r0_done} !== 2'b10) begin bad++; $display("FAIL freeze_busy got=%b exp=10", {r0_busy, r0_done}); end
      clk_enable = 1'b1;
      while (!r0_done && n < 100) begin tick(); n++; end
      total++; if (n !== 38) begin bad++; $display("FAIL freeze_latency got=%0d exp=38", n); end
      total++; if ({r0_hi, r0_lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin bad++; $display("FAIL freeze_result got=%h/%h exp=ffffffff/fffffffa", r0_hi, r0_lo); end
      clk_enable = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      total++; if (r0_done !== 1'b1) begin bad++; $display("FAIL freeze_done_hold got=%b exp=1", r0_done); end
      clk_enable = 1'b1;
      tick();
      total++; if (r0_done !== 1'b0) begin bad++; $display("FAIL freeze_done_release got=%b exp=0", r0_done); end
   endtask

   task automatic test_reset_abort();
      int n, nd; logic bs;
      run_op(0, 3'd4, 32'h77, 32'h0, 100, n, bs);
      op_valid = 1'b1;
      op_code  = 3'd1;
      op_a     = 32'h4000_0000;
      op_b     = 32'h0002_0001;
      tick();
      op_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      total++; if ({r0_hi, r0_lo} !== 64'h0) begin bad++; $display("FAIL abort_hilo got=%h/%h exp=0/0", r0_hi, r0_lo); end
      total++; if ({r0_ready, r0_busy, r0_done} !== 3'b100) begin bad++; $display("FAIL abort_flags got=%b exp=100", {r0_ready, r0_busy, r0_done}); end
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (r0_done) nd++;
      end
      total++; if (nd !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
   endtask

   task automatic test_fast_mult();
      int n; logic bs;
      pulse_reset();
      run_op(1, 3'd0, 32'hFFFF_FFFE, 32'h3, 100, n, bs);
      total++; if ({n, bs} !== {32'd1, 1'b0}) begin bad++; $display("FAIL fast_mult_latency got=%0d busy=%b exp=1 busy=0", n, bs); end
      total++; if ({r1_hi, r1_lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin bad++; $display("FAIL fast_mult_result got=%h/%h exp=ffffffff/fffffffa", r1_hi, r1_lo); end
      tick();
      run_op(1, 3'd1, 32'h4000_0000, 32'h0002_0001, 100, n, bs);
      total++; if (n !== 1) begin bad++; $display("FAIL fast_multu_latency got=%0d exp=1", n); end
      total++; if ({r1_hi, r1_lo} !== {32'h0000_8000, 32'h4000_0000}) begin bad++; $display("FAIL fast_multu_result got=%h/%h exp=00008000/40000000", r1_hi, r1_lo); end
   endtask

   task automatic test_width16();
      int n; logic bs;
      pulse_reset();
      run_op(2, 3'd0, 32'h8000, 32'h8000, 100, n, bs);
      total++; if (n !== 17) begin bad++; $display("FAIL w16_mult_latency got=%0d exp=17", n); end
      total++; if ({r2_hi, r2_lo} !== {16'h4000, 16'h0000}) begin bad++; $display("FAIL w16_mult_result got=%h/%h exp=4000/0000", r2_hi, r2_lo); end
      tick();
      pulse_reset();
      run_op(2, 3'd2, 32'hFFF9, 32'h2, 100, n, bs);
      total++; if (n !== 17) begin bad++; $display("FAIL w16_div_latency got=%0d exp=17", n); end
      total++; if ({r2_hi, r2_lo} !== {16'hFFFF, 16'hFFFD}) begin bad++; $display("FAIL w16_div_result got=%h/%h exp=ffff/fffd", r2_hi, r2_lo); end
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_multu();
      test_mult();
      test_div();
      test_div_by_zero();
      test_reserved();
      test_busy_ignore();
      test_enable_freeze();
      test_reset_abort();
      test_fast_mult();
      test_width16();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
